explode_sequencer: RTL and testbench

Drives the 4-bit position code consumed by the end-of-game explosion/"END" pixel generator, which outputs a 16x16 frame per code. When a collision is signalled it steps through the burst frames 1..4, flashes the full-red frame (code 5) against blank (code 0), and then holds the END frame (code 6) until restart. It also tells the game core to freeze play and reports game over. It sits between the collision detector and the end-frame generator, ahead of the display mux.

---
 rtl/explode_sequencer.sv | 130 +++++++++++++
 tb/tb_explode_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/explode_sequencer.sv
// explode_sequencer: end-of-game animation driver.
// On a collision it walks the burst frames 1..4, flashes red (5) against
// blank (0) FLASH_REPS times, then holds the END frame (6) until restart.
// All outputs come straight from registers or from decoding the state register.
module explode_sequencer #(
  parameter int DIV        = 12500000,  // clk cycles per animation step, >= 1
  parameter int FLASH_REPS = 3          // red/blank flash pairs, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       collide,
  input  logic       restart,
  output logic [3:0] position,
  output logic       freeze,
  output logic       game_over
);

  // Step counter runs 0..DIV-1; the flash counter covers 2*FLASH_REPS phases.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (2 * FLASH_REPS > 1) ? $clog2(2 * FLASH_REPS) : 1;
  localparam logic [CW-1:0] STEP_LAST  = CW'(DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_REPS - 1);

  // Frame codes understood by the end-frame generator.
  localparam logic [3:0] POS_BLANK = 4'd0;
  localparam logic [3:0] POS_FIRST = 4'd1;
  localparam logic [3:0] POS_LAST  = 4'd4;
  localparam logic [3:0] POS_RED   = 4'd5;
  localparam logic [3:0] POS_END   = 4'd6;

  // Three state bits leave spare encodings; any of them falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BURST   = 3'd1,
    FLASH   = 3'd2,
    ENDHOLD = 3'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      pos_reg, pos_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [FW-1:0]   flash_reg, flash_next;
  logic            step;

  // A step event is the last cycle of each DIV-cycle animation slot.
  assign step = (cnt_reg == STEP_LAST);

  // State, frame code and counters, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pos_reg   <= POS_BLANK;
      cnt_reg   <= '0;
      flash_reg <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      cnt_reg   <= cnt_next;
      flash_reg <= flash_next;
    end
  end

  // Next-state logic: advance the animation on step events, react to
  // collide only in IDLE and to restart only in ENDHOLD.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    flash_next = flash_reg;
    cnt_next   = step ? '0 : cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        // Counter held at zero so the first burst frame gets a full slot.
        cnt_next   = '0;
        flash_next = '0;
        pos_next   = POS_BLANK;
        if (collide) begin
          state_next = BURST;
          pos_next   = POS_FIRST;
        end
      end

      BURST: begin
        if (step) begin
          if (pos_reg == POS_LAST) begin
            state_next = FLASH;
            pos_next   = POS_RED;
            flash_next = '0;
          end else begin
            pos_next = pos_reg + 4'd1;
          end
        end
      end

      FLASH: begin
        if (step) begin
          if (flash_reg == FLASH_LAST) begin
            state_next = ENDHOLD;
            pos_next   = POS_END;
          end else begin
            pos_next   = (pos_reg == POS_RED) ? POS_BLANK : POS_RED;
            flash_next = flash_reg + 1'b1;
          end
        end
      end

      ENDHOLD: begin
        // Restart wins over a simultaneous collide: no burst this cycle.
        cnt_next = '0;
        pos_next = POS_END;
        if (restart) begin
          state_next = IDLE;
          pos_next   = POS_BLANK;
        end
      end

      default: begin
        state_next = IDLE;
        pos_next   = POS_BLANK;
        cnt_next   = '0;
        flash_next = '0;
      end
    endcase
  end

  assign position  = pos_reg;
  assign freeze    = (state_reg != IDLE);
  assign game_over = (state_reg == ENDHOLD);

endmodule

// File: tb/tb_explode_sequencer.sv
// Testbench for explode_sequencer: three instances (DIV/REPS = 4/3, 1/1, 3/3)
// checked every cycle against a timeline model through a scoreboard queue.
module tb_explode_sequencer;

  logic       clk = 1'b0;
  logic       rst_s [3];
  logic       col_s [3];
  logic       rs_s  [3];
  logic [3:0] pos_o [3];
  logic       frz_o [3];
  logic       go_o  [3];

  int divs [3] = '{4, 1, 3};
  int reps [3] = '{3, 1, 3};

  typedef struct {
    int cyc;
    int d;
    int pos;
    int frz;
    int go;
  } exp_t;

  exp_t sb [$];
  exp_t e;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  // Model state: whether a sequence is active and cycles elapsed since trigger.
  bit act [3];
  int k   [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  explode_sequencer #(.DIV(4), .FLASH_REPS(3)) dut_a (
    .clk(clk), .reset(rst_s[0]), .collide(col_s[0]), .restart(rs_s[0]),
    .position(pos_o[0]), .freeze(frz_o[0]), .game_over(go_o[0])
  );

  explode_sequencer #(.DIV(1), .FLASH_REPS(1)) dut_b (
    .clk(clk), .reset(rst_s[1]), .collide(col_s[1]), .restart(rs_s[1]),
    .position(pos_o[1]), .freeze(frz_o[1]), .game_over(go_o[1])
  );

  explode_sequencer #(.DIV(3), .FLASH_REPS(3)) dut_c (
    .clk(clk), .reset(rst_s[2]), .collide(col_s[2]), .restart(rs_s[2]),
    .position(pos_o[2]), .freeze(frz_o[2]), .game_over(go_o[2])
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Frame code k cycles after the triggering edge (k >= 1), from the
  // published timing: 4 burst slots, 2*reps flash slots, then END.
  function automatic int exp_pos(input int kk, input int div, input int rp);
    int j;
    if (kk - 1 < 4 * div) return 1 + (kk - 1) / div;
    j = (kk - 1 - 4 * div) / div;
    if (j < 2 * rp) return (j % 2 == 0) ? 5 : 0;
    return 6;
  endfunction

  // Predict the outputs after the coming edge from the inputs now applied,
  // queue them, then advance one clock.
  task automatic step();
    int p;
    for (int d = 0; d < 3; d++) begin
      if (rst_s[d]) begin
        act[d] = 1'b0;
      end else if (!act[d]) begin
        if (col_s[d]) begin
          act[d] = 1'b1;
          k[d]   = 1;
        end
      end else if (exp_pos(k[d], divs[d], reps[d]) == 6) begin
        if (rs_s[d]) act[d] = 1'b0;
      end else begin
        k[d]++;
      end
      p = act[d] ? exp_pos(k[d], divs[d], reps[d]) : 0;
      sb.push_back('{cyc + 1, d, p, act[d] ? 1 : 0, (p == 6) ? 1 : 0});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Compare each queued expectation once the DUT has produced that cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc)
        check($sformatf("late_entry d%0d", e.d), cyc, e.cyc);
      check($sformatf("position d%0d c%0d", e.d, e.cyc), int'(pos_o[e.d]), e.pos);
      check($sformatf("freeze d%0d c%0d", e.d, e.cyc), int'(frz_o[e.d]), e.frz);
      check($sformatf("game_over d%0d c%0d", e.d, e.cyc), int'(go_o[e.d]), e.go);
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1;
      col_s[d] = 1'b0;
      rs_s[d]  = 1'b0;
      act[d]   = 1'b0;
      k[d]     = 0;
    end

    // Reset for three cycles, then idle with collide low.
    steps(3);
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    steps(20);

    // Single collide pulse on the DIV=4 instance, full run into ENDHOLD.
    col_s[0] = 1'b1; step(); col_s[0] = 1'b0;
    steps(50);
    rs_s[0] = 1'b1; step(); rs_s[0] = 1'b0;
    steps(3);

    // Collide held high, restart mid-burst ignored; then restart+collide in ENDHOLD.
    col_s[0] = 1'b1;
    steps(10);
    rs_s[0] = 1'b1; step(); rs_s[0] = 1'b0;
    steps(45);
    rs_s[0] = 1'b1; step(); rs_s[0] = 1'b0;
    steps(2);
    col_s[0] = 1'b0;
    rst_s[0] = 1'b1; step(); rst_s[0] = 1'b0;
    steps(2);

    // Reset mid-flash, then a fresh sequence gets full step slots.
    col_s[0] = 1'b1; step(); col_s[0] = 1'b0;
    steps(23);
    rst_s[0] = 1'b1; step(); rst_s[0] = 1'b0;
    steps(5);
    col_s[0] = 1'b1; step(); col_s[0] = 1'b0;
    steps(8);
    rst_s[0] = 1'b1; step(); rst_s[0] = 1'b0;

    // DIV=1, REPS=1: one frame per cycle, END held until restart.
    col_s[1] = 1'b1; step(); col_s[1] = 1'b0;
    steps(12);
    rs_s[1] = 1'b1; step(); rs_s[1] = 1'b0;
    steps(3);

    // Randomised collide/restart (and rare reset) on the DIV=3 instance.
    for (int i = 0; i < 10000; i++) begin
      col_s[2] = ($urandom_range(0, 99) < 5);
      rs_s[2]  = ($urandom_range(0, 99) < 3);
      rst_s[2] = ($urandom_range(0, 999) == 0);
      step();
    end
    col_s[2] = 1'b0;
    rs_s[2]  = 1'b0;
    rst_s[2] = 1'b0;
    steps(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
